// File: rtl/pgr_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port between N message sources.
// Grants are held for a whole message; a stall watchdog revokes a grant that stops mid-message.
module pgr_uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   src_valid,
  input  logic [N*8-1:0] src_data,
  input  logic [N-1:0]   src_last,
  output logic [N-1:0]   src_ready,
  output logic [7:0]     tx_wr_data,
  output logic           tx_wr_req,
  input  logic           tx_wr_ready,
  output logic           busy,
  output logic [2:0]     grant_id,
  output logic           timeout_err,
  output logic [2:0]     timeout_src
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  localparam int              WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              WD_EN   = (TIMEOUT > 0);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  generate
    if (N < 2 || N > 8) begin : g_bad_n
      $error("pgr_uart_tx_arbiter: N must be in the range 2..8");
    end
  endgenerate

  logic [0:0]      state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic [2:0]      timeout_src_q, timeout_src_d;

  logic [7:0]   src_byte [N];
  logic [N-1:0] sel_hit;
  logic         xfer;
  logic         g_valid;
  logic         g_last;
  logic [7:0]   g_data;
  logic         xfer_fire;
  logic         pick_found;
  logic [2:0]   pick_idx;

  assign xfer = (state_q == ST_XFER);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_src
      assign src_byte[gi]  = src_data[8*gi +: 8];
      assign sel_hit[gi]   = (grant_q == 3'(gi));
      assign src_ready[gi] = xfer & sel_hit[gi] & tx_wr_ready;
    end
  endgenerate

  always_comb begin
    g_data = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (sel_hit[i]) g_data = src_byte[i];
    end
  end

  assign g_valid   = |(src_valid & sel_hit);
  assign g_last    = |(src_last & sel_hit);
  assign xfer_fire = xfer & g_valid & tx_wr_ready;

  assign tx_wr_req   = xfer_fire;
  assign tx_wr_data  = xfer ? g_data : 8'h00;
  assign busy        = xfer;
  assign grant_id    = grant_q;
  assign timeout_err = timeout_err_q;
  assign timeout_src = timeout_src_q;

  // Search starts one past the last serviced source so everyone gets a turn.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    idx        = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!pick_found && src_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = 3'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = 1'b0;
    timeout_src_d = timeout_src_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d  = pick_idx;
          wd_cnt_d = '0;
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        if (xfer_fire) begin
          wd_cnt_d = '0;
          if (g_last) begin
            rr_ptr_d = grant_q;
            state_d  = ST_IDLE;
          end
        end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
          // This stall cycle is the TIMEOUT-th in a row: drop the partial message.
          timeout_err_d = 1'b1;
          timeout_src_d = grant_q;
          rr_ptr_d      = grant_q;
          wd_cnt_d      = '0;
          state_d       = ST_IDLE;
        end else if (WD_EN) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= 3'd0;
      rr_ptr_q      <= 3'(N - 1);
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      timeout_src_q <= 3'd0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
      timeout_src_q <= timeout_src_d;
    end
  end

endmodule

// File: tb/tb_pgr_uart_tx_arbiter.sv
// Directed bench: three arbiters (TIMEOUT 256 / 8 / 0) share the stimulus; byte-queue sources
// follow the handshake of the currently selected instance.
module tb_pgr_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  src_valid;
  logic [31:0] src_data;
  logic [3:0]  src_last;
  logic        tx_rdy;

  logic [3:0] rdy  [3];
  logic [7:0] wd   [3];
  logic       wr   [3];
  logic       bsy  [3];
  logic [2:0] gid  [3];
  logic       terr [3];
  logic [2:0] tsrc [3];

  always #5 clk = ~clk;

  pgr_uart_tx_arbiter #(.N(4), .TIMEOUT(256)) u_a (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(rdy[0]), .tx_wr_data(wd[0]), .tx_wr_req(wr[0]), .tx_wr_ready(tx_rdy),
    .busy(bsy[0]), .grant_id(gid[0]), .timeout_err(terr[0]), .timeout_src(tsrc[0]));

  pgr_uart_tx_arbiter #(.N(4), .TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(rdy[1]), .tx_wr_data(wd[1]), .tx_wr_req(wr[1]), .tx_wr_ready(tx_rdy),
    .busy(bsy[1]), .grant_id(gid[1]), .timeout_err(terr[1]), .timeout_src(tsrc[1]));

  pgr_uart_tx_arbiter #(.N(4), .TIMEOUT(0)) u_c (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
    .src_ready(rdy[2]), .tx_wr_data(wd[2]), .tx_wr_req(wr[2]), .tx_wr_ready(tx_rdy),
    .busy(bsy[2]), .grant_id(gid[2]), .timeout_err(terr[2]), .timeout_src(tsrc[2]));

  // Source model: per-source byte queues of {last, data}.
  logic [8:0] mem [4][16];
  int         hd [4];
  int         tl [4];
  logic [3:0] en;
  int         sel;

  // Observation log of the selected instance.
  int         cyc;
  int         cap_n;
  logic [7:0] cap_data [32];
  logic [2:0] cap_src  [32];
  int         cap_cyc  [32];
  int         terr_cnt [3];
  int         terr_cyc [3];
  int         stall_seen;
  int         stall_leak;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %-22s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %-22s got=%0h", tag, got);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (hd[i] < tl[i]) begin
        src_valid[i]      = en[i];
        src_data[8*i +: 8] = mem[i][hd[i]][7:0];
        src_last[i]       = mem[i][hd[i]][8];
      end else begin
        src_valid[i]      = 1'b0;
        src_data[8*i +: 8] = 8'h00;
        src_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic push(input int s, input logic last, input logic [7:0] d);
    mem[s][tl[s]] = {last, d};
    tl[s]++;
  endtask

  task automatic tick();
    logic [3:0] fired;
    cyc++;
    drive();
    @(negedge clk);
    fired = src_valid & rdy[sel];
    if (wr[sel]) begin
      cap_data[cap_n] = wd[sel];
      cap_src[cap_n]  = gid[sel];
      cap_cyc[cap_n]  = cyc;
      cap_n++;
    end
    for (int k = 0; k < 3; k++) begin
      if (terr[k]) begin
        terr_cnt[k]++;
        terr_cyc[k] = cyc;
      end
    end
    if (!tx_rdy) begin
      stall_seen++;
      if (rdy[sel] != 4'd0 || wr[sel]) stall_leak++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (fired[i]) hd[i]++;
    drive();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    en     = 4'd0;
    tx_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    cyc        = 0;
    cap_n      = 0;
    stall_seen = 0;
    stall_leak = 0;
    for (int k = 0; k < 3; k++) begin
      terr_cnt[k] = 0;
      terr_cyc[k] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit got=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] exp_d [10];
    logic [2:0] exp_s [10];
    int         exp_c [10];

    sel = 0;
    en  = 4'd0;
    tx_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive();

    // Reset values
    #3;
    check_eq("rst_src_ready", 32'(rdy[0]), 32'h0);
    check_eq("rst_wr_req", 32'(wr[0]), 32'h0);
    check_eq("rst_wr_data", 32'(wd[0]), 32'h0);
    check_eq("rst_busy", 32'(bsy[0]), 32'h0);
    check_eq("rst_grant_id", 32'(gid[0]), 32'h0);
    check_eq("rst_timeout_err", 32'(terr[0]), 32'h0);
    check_eq("rst_timeout_src", 32'(tsrc[0]), 32'h0);

    // 1: single 3-byte message from source 0
    do_reset();
    sel = 0;
    push(0, 1'b0, 8'h11);
    push(0, 1'b0, 8'h22);
    push(0, 1'b1, 8'h33);
    en = 4'b0001;
    repeat (8) tick();
    check_eq("t1_count", 32'(cap_n), 32'd3);
    check_eq("t1_byte0", 32'(cap_data[0]), 32'h11);
    check_eq("t1_byte1", 32'(cap_data[1]), 32'h22);
    check_eq("t1_byte2", 32'(cap_data[2]), 32'h33);
    check_eq("t1_first_cycle", 32'(cap_cyc[0]), 32'd2);
    check_eq("t1_last_cycle", 32'(cap_cyc[2]), 32'd4);
    check_eq("t1_busy_after", 32'(bsy[0]), 32'h0);

    // 2: four sources contending, round-robin 0,1,2,3,0
    do_reset();
    sel = 0;
    push(0, 1'b0, 8'h00); push(0, 1'b1, 8'h01);
    push(0, 1'b0, 8'h02); push(0, 1'b1, 8'h03);
    push(1, 1'b0, 8'h10); push(1, 1'b1, 8'h11);
    push(2, 1'b0, 8'h20); push(2, 1'b1, 8'h21);
    push(3, 1'b0, 8'h30); push(3, 1'b1, 8'h31);
    en = 4'b1111;
    repeat (18) tick();
    exp_d = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
    exp_s = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0};
    exp_c = '{2, 3, 5, 6, 8, 9, 11, 12, 14, 15};
    check_eq("t2_count", 32'(cap_n), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("t2_data[%0d]", i), 32'(cap_data[i]), 32'(exp_d[i]));
      check_eq($sformatf("t2_src[%0d]", i), 32'(cap_src[i]), 32'(exp_s[i]));
      check_eq($sformatf("t2_cyc[%0d]", i), 32'(cap_cyc[i]), 32'(exp_c[i]));
    end

    // 3: source 1 stalls mid-message, TIMEOUT=8 instance revokes, source 2 next
    do_reset();
    sel = 1;
    push(1, 1'b0, 8'h55);
    push(2, 1'b1, 8'h77);
    en = 4'b0110;
    repeat (16) tick();
    check_eq("t3_first_src", 32'(cap_src[0]), 32'd1);
    check_eq("t3_terr_pulses", 32'(terr_cnt[1]), 32'd1);
    check_eq("t3_terr_cycle", 32'(terr_cyc[1]), 32'd11);
    check_eq("t3_timeout_src", 32'(tsrc[1]), 32'd1);
    check_eq("t3_count", 32'(cap_n), 32'd2);
    check_eq("t3_next_data", 32'(cap_data[1]), 32'h77);
    check_eq("t3_next_src", 32'(cap_src[1]), 32'd2);
    check_eq("t3_next_cycle", 32'(cap_cyc[1]), 32'd12);

    // 4: FIFO full for 5 cycles mid-message
    do_reset();
    sel = 0;
    push(0, 1'b0, 8'h41); push(0, 1'b0, 8'h42);
    push(0, 1'b0, 8'h43); push(0, 1'b1, 8'h44);
    en = 4'b0001;
    for (int t = 1; t <= 12; t++) begin
      tx_rdy = !(t >= 4 && t <= 8);
      tick();
    end
    tx_rdy = 1'b1;
    check_eq("t4_stall_cycles", 32'(stall_seen), 32'd5);
    check_eq("t4_stall_leak", 32'(stall_leak), 32'd0);
    check_eq("t4_count", 32'(cap_n), 32'd4);
    check_eq("t4_byte2", 32'(cap_data[2]), 32'h43);
    check_eq("t4_byte3", 32'(cap_data[3]), 32'h44);
    check_eq("t4_resume_cycle", 32'(cap_cyc[2]), 32'd9);
    check_eq("t4_no_timeout", 32'(terr_cnt[0]), 32'd0);

    // 5: reset asserted while byte 2 of 4 is presented
    do_reset();
    sel = 0;
    push(0, 1'b0, 8'h51); push(0, 1'b0, 8'h52);
    push(0, 1'b0, 8'h53); push(0, 1'b1, 8'h54);
    en = 4'b0001;
    tick();
    tick();
    #2;
    check_eq("t5_pre_rst_req", 32'(wr[0]), 32'h1);
    check_eq("t5_pre_rst_data", 32'(wd[0]), 32'h52);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_req", 32'(wr[0]), 32'h0);
    check_eq("t5_rst_ready", 32'(rdy[0]), 32'h0);
    check_eq("t5_rst_busy", 32'(bsy[0]), 32'h0);
    check_eq("t5_rst_data", 32'(wd[0]), 32'h0);
    check_eq("t5_rst_grant", 32'(gid[0]), 32'h0);
    do_reset();
    push(0, 1'b1, 8'h60);
    push(1, 1'b1, 8'h61);
    en = 4'b0011;
    repeat (6) tick();
    check_eq("t5_after_src", 32'(cap_src[0]), 32'd0);
    check_eq("t5_after_data", 32'(cap_data[0]), 32'h60);
    check_eq("t5_after_cycle", 32'(cap_cyc[0]), 32'd2);
    check_eq("t5_second_src", 32'(cap_src[1]), 32'd1);

    // 6: TIMEOUT=0 instance never fires over a 1000-cycle stall
    do_reset();
    sel = 2;
    push(3, 1'b0, 8'h71);
    push(3, 1'b1, 8'h72);
    en = 4'b1000;
    repeat (2) tick();
    en = 4'b0000;
    repeat (1000) tick();
    check_eq("t6_no_timeout", 32'(terr_cnt[2]), 32'd0);
    check_eq("t6_busy_held", 32'(bsy[2]), 32'h1);
    check_eq("t6_grant_held", 32'(gid[2]), 32'd3);
    check_eq("t6_t256_fired", 32'(terr_cnt[0]), 32'd1);
    check_eq("t6_t256_src", 32'(tsrc[0]), 32'd3);
    en = 4'b1000;
    repeat (3) tick();
    check_eq("t6_count", 32'(cap_n), 32'd2);
    check_eq("t6_resume_data", 32'(cap_data[1]), 32'h72);
    check_eq("t6_resume_cycle", 32'(cap_cyc[1]), 32'd1003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
